// File: rtl/e1ofn_rtl_bridge.sv
// e1ofn_rtl_bridge: e1ofN <-> valid/ready bridge with one receive and one send path.
// Define BRIDGE_SYNC_EN to pass in_d and out_e through 2-flop synchronizers.
module e1ofn_rtl_bridge #(
    parameter int M = 9,
    parameter int N = 2,
    localparam int L = $clog2(N),
    localparam int W = M * L
) (
    input  logic           CLK,
    input  logic           _RESET,
    input  logic [M*N-1:0] in_d,
    output logic           in_e,
    output logic [W-1:0]   rx_data,
    output logic           rx_valid,
    input  logic           rx_ready,
    output logic           rx_err,
    input  logic [W-1:0]   tx_data,
    input  logic           tx_valid,
    output logic           tx_ready,
    output logic [M*N-1:0] out_d,
    input  logic           out_e
);
    typedef enum logic [1:0] {WAIT_DATA, WAIT_NEUTRAL, WAIT_CONSUME} rx_state_t;
    typedef enum logic [1:0] {IDLE, DRIVE, RTZ} tx_state_t;

    logic [M*N-1:0] d_s;
    logic           e_s;

`ifdef BRIDGE_SYNC_EN
    logic [M*N-1:0] d_meta;
    logic           e_meta;
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            d_meta <= '0;
            d_s    <= '0;
            e_meta <= 1'b0;
            e_s    <= 1'b0;
        end else begin
            d_meta <= in_d;
            d_s    <= d_meta;
            e_meta <= out_e;
            e_s    <= e_meta;
        end
    end
`else
    assign d_s = in_d;
    assign e_s = out_e;
`endif

    rx_state_t      rx_state, rx_next;
    tx_state_t      tx_state, tx_next;
    logic           complete, multi;
    logic [W-1:0]   decoded, rx_data_n;
    logic [M*N-1:0] encoded, out_d_n;
    logic           in_e_n, rx_valid_n, rx_err_n;

    // Lowest-index hot rail wins so a multi-hot digit still decodes deterministically.
    always_comb begin
        complete = 1'b1;
        multi    = 1'b0;
        decoded  = '0;
        for (int i = 0; i < M; i++) begin
            complete &= |d_s[i*N +: N];
            multi    |= ($countones(d_s[i*N +: N]) > 1);
            for (int v = N - 1; v >= 0; v--)
                if (d_s[i*N + v]) decoded[i*L +: L] = L'(v);
        end
    end

    always_comb begin
        encoded = '0;
        for (int i = 0; i < M; i++)
            encoded[i*N +: N] = (int'(tx_data[i*L +: L]) >= N) ? N'(1) << (N - 1)
                                                               : N'(1) << tx_data[i*L +: L];
    end

    always_comb begin
        rx_next    = rx_state;
        in_e_n     = in_e;
        rx_valid_n = rx_valid & ~rx_ready;
        rx_data_n  = rx_data;
        rx_err_n   = 1'b0;
        case (rx_state)
            WAIT_DATA: if (complete) begin
                rx_next    = WAIT_NEUTRAL;
                in_e_n     = 1'b0;
                rx_valid_n = 1'b1;
                rx_data_n  = decoded;
                rx_err_n   = multi;
            end
            WAIT_NEUTRAL: if (d_s == '0) rx_next = WAIT_CONSUME;
            WAIT_CONSUME: if (!rx_valid) begin
                rx_next = WAIT_DATA;
                in_e_n  = 1'b1;
            end
            default: rx_next = WAIT_DATA;
        endcase
    end

    always_comb begin
        tx_next = tx_state;
        out_d_n = out_d;
        case (tx_state)
            IDLE: if (tx_valid && tx_ready) begin
                tx_next = DRIVE;
                out_d_n = encoded;
            end
            DRIVE: if (!e_s) begin
                tx_next = RTZ;
                out_d_n = '0;
            end
            RTZ: if (e_s) tx_next = IDLE;
            default: begin
                tx_next = IDLE;
                out_d_n = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            rx_state <= WAIT_DATA;
            tx_state <= IDLE;
            in_e     <= 1'b1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_err   <= 1'b0;
            out_d    <= '0;
            tx_ready <= 1'b0;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
            in_e     <= in_e_n;
            rx_valid <= rx_valid_n;
            rx_data  <= rx_data_n;
            rx_err   <= rx_err_n;
            out_d    <= out_d_n;
            tx_ready <= (tx_next == IDLE) && e_s;
        end
    end
endmodule

// File: tb/tb_e1ofn_rtl_bridge.sv
// tb_e1ofn_rtl_bridge: directed send/receive/reset checks plus a loopback stream.
module tb_e1ofn_rtl_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  a_in_d, a_out_d;
    logic        a_in_e, a_rx_valid, a_rx_ready, a_rx_err, a_tx_valid, a_tx_ready, a_out_e;
    logic [3:0]  a_rx_data, a_tx_data;

    logic [17:0] b_in_d, b_out_d;
    logic        b_in_e, b_rx_valid, b_rx_ready, b_rx_err, b_tx_valid, b_tx_ready, b_out_e;
    logic [8:0]  b_rx_data, b_tx_data;

    logic [7:0]  c_d;
    logic        c_e, c_rx_valid, c_rx_ready, c_rx_err, c_tx_valid, c_tx_ready;
    logic [3:0]  c_rx_data, c_tx_data;

    logic [8:0]  qb[$];
    logic [3:0]  qc[$];

    e1ofn_rtl_bridge #(.M(2), .N(4)) u_a (
        .CLK(clk), ._RESET(rst_n), .in_d(a_in_d), .in_e(a_in_e), .rx_data(a_rx_data),
        .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_err(a_rx_err), .tx_data(a_tx_data),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .out_d(a_out_d), .out_e(a_out_e));

    e1ofn_rtl_bridge #(.M(9), .N(2)) u_b (
        .CLK(clk), ._RESET(rst_n), .in_d(b_in_d), .in_e(b_in_e), .rx_data(b_rx_data),
        .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_err(b_rx_err), .tx_data(b_tx_data),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .out_d(b_out_d), .out_e(b_out_e));

    e1ofn_rtl_bridge #(.M(2), .N(4)) u_c (
        .CLK(clk), ._RESET(rst_n), .in_d(c_d), .in_e(c_e), .rx_data(c_rx_data),
        .rx_valid(c_rx_valid), .rx_ready(c_rx_ready), .rx_err(c_rx_err), .tx_data(c_tx_data),
        .tx_valid(c_tx_valid), .tx_ready(c_tx_ready), .out_d(c_d), .out_e(c_e));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] enc2(input logic [8:0] t);
        logic [17:0] r;
        for (int i = 0; i < 9; i++) r[2*i +: 2] = t[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [31:0] pop_b();
        return (qb.size() > 0) ? 32'(qb.pop_front()) : 32'hDEAD;
    endfunction

    initial begin
        logic [8:0] tok;
        a_in_d = '0; a_rx_ready = 1'b0; a_tx_data = '0; a_tx_valid = 1'b0; a_out_e = 1'b1;
        b_in_d = '0; b_rx_ready = 1'b0; b_tx_data = '0; b_tx_valid = 1'b0; b_out_e = 1'b1;
        c_rx_ready = 1'b0; c_tx_data = '0; c_tx_valid = 1'b0;
        repeat (3) tick();
        chk("rst_in_e", a_in_e, 1);
        chk("rst_rx_valid", a_rx_valid, 0);
        chk("rst_rx_data", a_rx_data, 0);
        chk("rst_rx_err", a_rx_err, 0);
        chk("rst_out_d", a_out_d, 0);
        chk("rst_tx_ready", a_tx_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_tx_ready", a_tx_ready, 1);

        // Send path
        a_tx_data = 4'b1001; a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        chk("send_out_d", a_out_d, 8'b0100_0010);
        chk("send_tx_ready_low", a_tx_ready, 0);
        tick();
        chk("send_hold", a_out_d, 8'b0100_0010);
        a_out_e = 1'b0;
        tick();
        chk("send_rtz", a_out_d, 0);
        chk("send_rtz_ready", a_tx_ready, 0);
        a_out_e = 1'b1;
        tick();
        chk("send_idle_ready", a_tx_ready, 1);

        // Receive path: partial then complete token
        tok = 9'h1A5;
        b_in_d = enc2(tok) & ~(18'h3 << 16);
        repeat (2) tick();
        chk("partial_in_e", b_in_e, 1);
        chk("partial_valid", b_rx_valid, 0);
        b_in_d = enc2(tok);
        qb.push_back(tok);
        tick();
        chk("rx_valid", b_rx_valid, 1);
        chk("rx_in_e_ack", b_in_e, 0);
        chk("rx_err_clean", b_rx_err, 0);
        chk("rx_data", b_rx_data, pop_b());
        b_in_d = '0;
        repeat (2) tick();
        chk("rx_hold_in_e", b_in_e, 0);
        chk("rx_hold_valid", b_rx_valid, 1);
        b_rx_ready = 1'b1;
        tick();
        b_rx_ready = 1'b0;
        chk("rx_consumed", b_rx_valid, 0);
        chk("rx_in_e_still_low", b_in_e, 0);
        tick();
        chk("rx_in_e_rise", b_in_e, 1);

        // Multi-hot digit 0
        b_in_d = enc2(9'h000) | 18'h3;
        qb.push_back(9'h000);
        tick();
        chk("mh_valid", b_rx_valid, 1);
        chk("mh_err", b_rx_err, 1);
        chk("mh_bit0", b_rx_data[0], 0);
        chk("mh_data", b_rx_data, pop_b());
        tick();
        chk("mh_err_pulse", b_rx_err, 0);
        b_in_d = '0; b_rx_ready = 1'b1;
        repeat (2) tick();
        b_rx_ready = 1'b0;
        chk("mh_in_e_back", b_in_e, 1);

        // Reset in the middle of DRIVE
        a_tx_data = 4'b0110; a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        chk("mid_drive_out_d", a_out_d, 8'h24);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_d", a_out_d, 0);
        chk("mid_rst_in_e", a_in_e, 1);
        chk("mid_rst_rx_valid", a_rx_valid, 0);
        chk("mid_rst_tx_ready", a_tx_ready, 0);
        tick();
        chk("held_rst_out_d", a_out_d, 0);
        chk("held_rst_tx_ready", a_tx_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_tx_ready", a_tx_ready, 1);

        // Loopback stream with random consumer backpressure
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    int wait_cnt;
                    c_tx_data = 4'($urandom);
                    c_tx_valid = 1'b1;
                    wait_cnt = 0;
                    while (!c_tx_ready && wait_cnt < 200) begin
                        tick();
                        wait_cnt++;
                    end
                    chk("lb_tx_wait", 32'(wait_cnt < 200), 1);
                    qc.push_back(c_tx_data);
                    tick();
                    c_tx_valid = 1'b0;
                end
            end
            begin
                int got;
                got = 0;
                for (int cyc = 0; cyc < 4000 && got < 16; cyc++) begin
                    tick();
                    c_rx_ready = 1'($urandom_range(0, 1));
                    if (c_rx_valid && c_rx_ready) begin
                        chk("lb_data", c_rx_data, (qc.size() > 0) ? 32'(qc.pop_front()) : 32'hDEAD);
                        chk("lb_err", c_rx_err, 0);
                        got++;
                    end
                end
                chk("lb_count", got, 16);
            end
        join
        c_rx_ready = 1'b1;
        repeat (20) tick();
        chk("lb_no_dup", c_rx_valid, 0);
        chk("lb_queue_empty", qc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/e1ofn_rtl_bridge.md
# e1ofn_rtl_bridge

Clocked bridge between delay-insensitive e1ofN (M digits, each 1-of-N, active-high enable) channels and synchronous valid/ready RTL streams. It holds one receive path (e1ofN in, RTL out) and one send path (RTL in, e1ofN out). It sits at the boundary of every clocked process body that talks to an asynchronous e1ofN network channel.

## Interface
- M, default 9: digits per channel token.
- N, default 2: rails per digit; N ≥ 2.
- L (derived, not overridable): bits per digit, ceil(log2 N).
- W (derived, not overridable): RTL data width, M*L.
- CLK  in  1  single clock; all state on rising edge.
- _RESET  in  1  asynchronous, active-low reset.
- in_d  in  M*N  receive rails; digit i on [i*N +: N], rail v hot = value v.
- in_e  out  1  receive enable (1 = ready for token, 0 = acknowledge).
- rx_data  out  W  received token; digit i value in [i*L +: L].
- rx_valid  out  1  rx_data holds an unconsumed token.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready.
- rx_err  out  1  one-cycle pulse: a captured digit had more than one hot rail.
- tx_data  in  W  token to send, same packing as rx_data.
- tx_valid  in  1  producer offers tx_data.
- tx_ready  out  1  token accepted when tx_valid & tx_ready.
- out_d  out  M*N  send rails, same encoding as in_d.
- out_e  in  1  enable from downstream receiver.

## Operation
- Receive FSM: WAIT_DATA → WAIT_NEUTRAL → WAIT_CONSUME → WAIT_DATA.
- WAIT_DATA (in_e=1): complete when every digit has ≥1 hot rail. On completion, latch rx_data from the lowest-index hot rail per digit, set rx_valid=1, drive in_e=0, pulse rx_err if any digit is multi-hot, go to WAIT_NEUTRAL.
- WAIT_NEUTRAL: stay until all in_d rails are 0, then go to WAIT_CONSUME. rx_valid/rx_ready handshakes are legal in any state.
- WAIT_CONSUME: once rx_valid is 0 (token consumed), drive in_e=1 and go to WAIT_DATA. Only one token is buffered, so the next token is never acknowledged before the previous one is consumed.
- Send FSM: IDLE → DRIVE → RTZ → IDLE.
- IDLE: out_d=0. tx_ready = out_e. On tx_valid & tx_ready, register the 1-of-N encoding of tx_data onto out_d (exactly one rail hot per digit) and go to DRIVE.
- DRIVE: hold out_d. When out_e=0, clear out_d to all-zero and go to RTZ.
- RTZ: when out_e=1, go to IDLE.
- If a tx_data digit value is ≥ N (N not a power of 2), drive rail N-1.
- All outputs are registered; no combinational path from in_d/out_e to any output.

## Timing
- Reset values: in_e=1, rx_valid=0, rx_data=0, rx_err=0, out_d=0, tx_ready=0. Both FSMs reset to their first state.
- Receive: completion sampled at edge k gives rx_valid=1 and in_e=0 after edge k. rx_valid falls the cycle after acceptance.
- in_e rises one cycle after both conditions hold: neutral seen and rx_valid=0. If acceptance and neutral happen in the same cycle, in_e rises the next cycle.
- Send: acceptance at edge k gives out_d valid after edge k. out_d clears the cycle after out_e=0 is sampled.
- Reset asserted mid-handshake aborts immediately and forces the reset values. The network side must also be reset.

## Configuration
- BRIDGE_SYNC_EN defined: in_d and out_e each pass through a 2-flop synchronizer before FSM use. Every input-to-response latency grows by 2 cycles.
- BRIDGE_SYNC_EN not defined: in_d and out_e are used directly and are required to be synchronous to CLK.

## Test plan
- Reset: with M=2, N=4, assert _RESET=0 mid-DRIVE → out_d=0, in_e=1, rx_valid=0, tx_ready=0 (tx_ready follows out_e on the next cycle) while reset is held.
- Send: M=2, N=4, tx_data=4'b1001 → out_d=8'b0100_0010 one cycle after accept. Drop out_e → out_d=0. Raise out_e → tx_ready=1.
- Receive: M=9, N=2, apply rails encoding 9'h1A5 → rx_valid=1, rx_data=9'h1A5, in_e=0. Hold rx_ready=0 and neutralize rails → in_e stays 0. Raise rx_ready → in_e=1 one cycle after rx_valid falls.
- Partial token: drive 8 of 9 digits → no capture, in_e stays 1. Drive the 9th digit → capture next cycle.
- Multi-hot: digit 0 with both rails hot → rx_err pulses one cycle, rx_data bit 0 = 0.
- Loopback: connect out_d→in_d and in_e→out_e, stream 16 random tokens with random rx_ready → every token received in order, no loss or duplication.
